// File: rtl/prog_loader.sv
// Boot-time program loader: framed byte stream -> 8K x 8 memory.
// Holds the CPU in reset until a frame loads with a good checksum.
module prog_loader #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int HI_W = ADDR_W - DATA_W;
  localparam int TW   = (TIMEOUT_CYC > 0) ?
                        $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_csum;
  logic [TW-1:0]     r_timer;

  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_busy;
  logic              w_nbusy;
  logic              w_tmo;
  logic              w_acc;
  logic              w_go;
  logic              w_last;
  logic [ADDR_W-1:0] w_len;

  assign w_busy = (r_state == S_LEN_HI) ||
                  (r_state == S_LEN_LO) ||
                  (r_state == S_DATA)   ||
                  (r_state == S_CSUM);

  assign w_nbusy = (w_next == S_LEN_HI) ||
                   (w_next == S_LEN_LO) ||
                   (w_next == S_DATA)   ||
                   (w_next == S_CSUM);

  // A timed-out load stops taking bytes in the same cycle it expires,
  // so the byte on the bus is never written after the fact.
  assign w_tmo = (TIMEOUT_CYC != 0) && w_busy &&
                 (r_timer == TW'(TIMEOUT_CYC));

  assign s_ready = w_busy && !w_tmo;
  assign w_acc   = s_valid && s_ready;
  assign w_go    = start && !w_busy;
  assign w_len   = {r_len[ADDR_W-1:DATA_W], s_data};
  assign w_last  = (r_ptr == (r_len - ADDR_W'(1)));

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_reset = r_cpu_reset;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a timeout overrides whatever the frame is doing.
  always_comb begin
    w_next = r_state;
    if (w_tmo) begin
      w_next = S_ERR;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) w_next = S_LEN_HI;
        end
        S_LEN_HI: begin
          if (w_acc) w_next = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (w_acc) begin
            w_next = (w_len == '0) ? S_CSUM : S_DATA;
          end
        end
        S_DATA: begin
          if (w_acc && w_last) w_next = S_CSUM;
        end
        S_CSUM: begin
          if (w_acc) begin
            w_next = (s_data == r_csum) ? S_DONE : S_ERR;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Status outputs follow the state being entered, so they change
  // on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_busy      <= w_nbusy;
      r_done      <= (w_next == S_DONE);
      r_err       <= (w_next == S_ERR);
      r_cpu_reset <= (w_next != S_DONE);
    end
  end

  // Frame datapath: length capture, checksum, pointer and the
  // one-cycle-late memory write of each payload byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len       <= '0;
      r_ptr       <= '0;
      r_csum      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_go) begin
        r_len  <= '0;
        r_ptr  <= '0;
        r_csum <= '0;
      end
      if (w_acc) begin
        case (r_state)
          S_LEN_HI: begin
            r_len <= {s_data[HI_W-1:0], {DATA_W{1'b0}}};
          end
          S_LEN_LO: begin
            r_len[DATA_W-1:0] <= s_data;
          end
          S_DATA: begin
            r_csum      <= r_csum + s_data;
            r_ptr       <= r_ptr + ADDR_W'(1);
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_ptr;
            r_mem_wdata <= s_data;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Idle-gap timer: cleared outside a load and on every accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
    end else if (!w_busy || w_acc) begin
      r_timer <= '0;
    end else if ((TIMEOUT_CYC != 0) && !w_tmo) begin
      r_timer <= r_timer + TW'(1);
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the RISC CPU and its 8K x 8 memory.
- Accepts a framed byte stream over a valid/ready interface and writes the payload into memory from address 0.
- Verifies an 8-bit additive checksum over the payload.
- Holds the CPU in reset until a load completes successfully, then releases it.

Parameters:
- ADDR_W, 13, memory address width; matches the CPU address bus.
- DATA_W, 8, byte width of the stream and the memory data.
- TIMEOUT_CYC, 0, max idle cycles between accepted bytes while loading; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load.
- s_valid  input  1  stream byte valid.
- s_data  input  DATA_W  stream byte.
- s_ready  output  1  loader can accept a byte this cycle.
- mem_addr  output  ADDR_W  memory write address.
- mem_wdata  output  DATA_W  memory write data.
- mem_we  output  1  memory write strobe, one cycle per byte.
- cpu_reset  output  1  drives the CPU reset input; high holds the CPU in reset.
- busy  output  1  load in progress.
- done  output  1  last load succeeded; CPU released.
- err  output  1  last load failed (checksum mismatch or timeout).

Behaviour:
- The design has one clock domain. Reset is synchronous and active-high; the clock port is clk and the reset port is reset.
- All outputs are registered except s_ready, which is decoded from the state.
- Reset values: state=IDLE, cpu_reset=1, busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0, length=0, csum=0, timer=0.
- A byte is accepted on a rising edge where s_valid=1 and s_ready=1.
- s_ready=1 only in states LEN_HI, LEN_LO, DATA and CSUM.
- Frame format: LEN_HI, LEN_LO, payload[0..N-1], CSUM.
  - N = {LEN_HI[4:0], LEN_LO}; LEN_HI[7:5] are ignored.
  - Maximum N is 8191.
- State transitions:
  - IDLE: on start go to LEN_HI. Set busy=1, done=0, err=0, cpu_reset=1, and clear csum and the write pointer.
  - LEN_HI: on accept, latch the high bits and go to LEN_LO.
  - LEN_LO: on accept, latch the low byte. If N=0 go to CSUM, else go to DATA.
  - DATA: on accept, csum <= csum + byte (mod 256) and schedule a write; the pointer increments. After the Nth byte go to CSUM.
  - CSUM: on accept, if byte == csum go to DONE, else go to ERR.
  - DONE: done=1, busy=0, cpu_reset=0. On start go to LEN_HI (cpu_reset=1 again).
  - ERR: err=1, busy=0, cpu_reset stays 1. On start go to LEN_HI.
- Write timing: the cycle after the k-th payload byte is accepted, mem_we=1 for exactly one cycle with mem_addr=k and mem_wdata=byte.
  - Back-to-back accepts give back-to-back writes.
  - mem_we is never high outside these cycles.
- Completion timing: done/err and the cpu_reset change take effect the cycle after the CSUM byte is accepted.
  - The final payload write always completes before cpu_reset deasserts.
- start is ignored while busy=1 (LEN_HI..CSUM).
- Timeout (TIMEOUT_CYC>0): the timer resets on every accept and on entering LEN_HI, and increments every busy cycle without an accept.
  - When timer reaches TIMEOUT_CYC, go to ERR on the next edge. No further writes occur.
- Reset mid-load: everything returns to its reset values. A pending write is dropped, so mem_we=0 the cycle after reset. cpu_reset=1.
- Write-pointer wrap cannot occur because N ≤ 8191.
- The checksum wraps modulo 256.

Test Plan:
- Normal load: start, then bytes 00 03 11 22 33 66 -> writes (0,11) (1,22) (2,33) on consecutive cycles after each accept; done=1, err=0, cpu_reset=0 one cycle after 66 is accepted.
- Zero length: start, then 00 00 00 -> no mem_we pulses; done=1, cpu_reset=0.
- Bad checksum plus retry: start, then 00 02 AA 55 00 -> 2 writes, then err=1 and cpu_reset stays 1. A second start with 00 02 AA 55 FF -> done=1, err=0.
- Backpressure/timeout with TIMEOUT_CYC=8: random s_valid gaps of 1-7 cycles -> load succeeds and the writes match the accepted bytes. A 9-cycle gap after the 2nd payload byte -> err=1, exactly 2 writes, cpu_reset=1.
- Start while busy: a start pulse during DATA -> no state change, the pointer continues, and the load completes normally. A start in DONE -> cpu_reset=1 the next cycle and busy=1.
- Reset mid-load: reset asserted the same cycle as a payload accept -> mem_we=0 the next cycle, all outputs at reset values, s_ready=0 until the next start.
